gemm_store_controller: RTL and testbench



---
 rtl/gemm_pkg.sv | 15 +
 rtl/gemm_store_controller.sv | 142 ++++++++++++++
 tb/tb_gemm_store_controller.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gemm_pkg.sv
// Shared GEMM controller definitions: datapath widths, interface encodings and
// controller state types.
package gemm_pkg;

  localparam int ADDR_W = 32;
  localparam int SIZE_W = 5;

  localparam logic RDWR_WRITE = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } store_state_t;

endpackage : gemm_pkg

// File: rtl/gemm_store_controller.sv
// Store-phase sequencer: streams C tile rows from the accumulator array out
// through the shared memory interface, reading each row one cycle ahead.
module gemm_store_controller
  import gemm_pkg::*;
#(
  parameter int ADDR_W = gemm_pkg::ADDR_W,
  parameter int SIZE_W = gemm_pkg::SIZE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              can_store,
  input  logic [ADDR_W-1:0] tile_C_addr,
  input  logic [ADDR_W-1:0] tile_C_stride,
  input  logic [SIZE_W-1:0] msize,
  input  logic [SIZE_W-1:0] nsize,
  input  logic              mem_ready,
  output logic              gen_addr_store,
  output logic [ADDR_W-1:0] next_row_addr_store,
  output logic              interface_en_store,
  output logic [SIZE_W-1:0] interface_control_store,
  output logic              interface_rdwr_store,
  output logic              accum_rd_en,
  output logic [SIZE_W-1:0] accum_rd_row,
  output logic              done_store,
  output logic              busy
);

  store_state_t      state_q, state_d;
  logic [SIZE_W-1:0] row_cnt_q, row_cnt_d;
  logic [ADDR_W-1:0] row_addr_q, row_addr_d;
  logic [SIZE_W-1:0] msize_q, msize_d;
  logic [SIZE_W-1:0] nsize_q, nsize_d;
  logic [ADDR_W-1:0] stride_q, stride_d;

  logic              last_row;
  logic [ADDR_W-1:0] step_addr;

  assign last_row  = (row_cnt_q == msize_q - SIZE_W'(1));
  assign step_addr = row_addr_q + stride_q;

  // NOTE: every output and next-state value gets a default first so no path
  // leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d                 = state_q;
    row_cnt_d               = row_cnt_q;
    row_addr_d              = row_addr_q;
    msize_d                 = msize_q;
    nsize_d                 = nsize_q;
    stride_d                = stride_q;
    gen_addr_store          = 1'b0;
    next_row_addr_store     = '0;
    interface_en_store      = 1'b0;
    interface_control_store = '0;
    interface_rdwr_store    = 1'b0;
    accum_rd_en             = 1'b0;
    accum_rd_row            = '0;
    done_store              = 1'b0;
    busy                    = (state_q == WRITE);

    unique case (state_q)
      IDLE: begin
        if (can_store) begin
          if (msize != '0) begin
            // Issued combinationally so the upstream controller can forward
            // them during its final compute cycle.
            gen_addr_store      = 1'b1;
            next_row_addr_store = tile_C_addr;
            accum_rd_en         = 1'b1;
            accum_rd_row        = '0;
            row_addr_d          = tile_C_addr;
            row_cnt_d           = '0;
            msize_d             = msize;
            nsize_d             = nsize;
            stride_d            = tile_C_stride;
            state_d             = WRITE;
          end else begin
            done_store = 1'b1;
          end
        end
      end

      WRITE: begin
        if (!can_store) begin
          row_cnt_d = '0;
          state_d   = IDLE;
        end else if (mem_ready) begin
          interface_en_store      = 1'b1;
          interface_rdwr_store    = RDWR_WRITE;
          interface_control_store = nsize_q;
          if (last_row) begin
            done_store = 1'b1;
            row_cnt_d  = '0;
            state_d    = IDLE;
          end else begin
            gen_addr_store      = 1'b1;
            next_row_addr_store = step_addr;
            accum_rd_en         = 1'b1;
            accum_rd_row        = row_cnt_q + SIZE_W'(1);
            row_addr_d          = step_addr;
            row_cnt_d           = row_cnt_q + SIZE_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Reset silences the combinational start path immediately, not at the next edge.
    if (rst) begin
      gen_addr_store          = 1'b0;
      next_row_addr_store     = '0;
      interface_en_store      = 1'b0;
      interface_control_store = '0;
      interface_rdwr_store    = 1'b0;
      accum_rd_en             = 1'b0;
      accum_rd_row            = '0;
      done_store              = 1'b0;
      busy                    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      row_cnt_q  <= '0;
      row_addr_q <= '0;
      msize_q    <= '0;
      nsize_q    <= '0;
      stride_q   <= '0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      row_addr_q <= row_addr_d;
      msize_q    <= msize_d;
      nsize_q    <= nsize_d;
      stride_q   <= stride_d;
    end
  end

endmodule : gemm_store_controller

// File: tb/tb_gemm_store_controller.sv
// Directed bench for gemm_store_controller: per-cycle expected output vectors
// for each store scenario, compared on the falling edge.
module tb_gemm_store_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        can_store;
  logic [31:0] tile_C_addr;
  logic [31:0] tile_C_stride;
  logic [4:0]  msize;
  logic [4:0]  nsize;
  logic        mem_ready;
  logic        gen_addr_store;
  logic [31:0] next_row_addr_store;
  logic        interface_en_store;
  logic [4:0]  interface_control_store;
  logic        interface_rdwr_store;
  logic        accum_rd_en;
  logic [4:0]  accum_rd_row;
  logic        done_store;
  logic        busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  gemm_store_controller dut (
    .clk                     (clk),
    .rst                     (rst),
    .can_store               (can_store),
    .tile_C_addr             (tile_C_addr),
    .tile_C_stride           (tile_C_stride),
    .msize                   (msize),
    .nsize                   (nsize),
    .mem_ready               (mem_ready),
    .gen_addr_store          (gen_addr_store),
    .next_row_addr_store     (next_row_addr_store),
    .interface_en_store      (interface_en_store),
    .interface_control_store (interface_control_store),
    .interface_rdwr_store    (interface_rdwr_store),
    .accum_rd_en             (accum_rd_en),
    .accum_rd_row            (accum_rd_row),
    .done_store              (done_store),
    .busy                    (busy)
  );

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        gen;
    logic [31:0] addr;
    logic        en;
    logic [4:0]  ctrl;
    logic        rdwr;
    logic        rd_en;
    logic [4:0]  row;
  } out_t;

  typedef struct {
    logic cs;
    logic mr;
    out_t exp;
  } step_t;

  out_t obs;
  assign obs = {busy, done_store, gen_addr_store, next_row_addr_store, interface_en_store,
                interface_control_store, interface_rdwr_store, accum_rd_en, accum_rd_row};

  // Expected vector; a write is always flagged as such on rdwr.
  function automatic out_t o(input logic gen, input logic [31:0] addr, input logic en,
                             input logic [4:0] ctrl, input logic rd_en, input logic [4:0] row,
                             input logic done, input logic bsy);
    out_t r;
    r.busy  = bsy;
    r.done  = done;
    r.gen   = gen;
    r.addr  = addr;
    r.en    = en;
    r.ctrl  = ctrl;
    r.rdwr  = en;
    r.rd_en = rd_en;
    r.row   = row;
    return r;
  endfunction

  localparam out_t ZERO = '0;

  task automatic test_reset();
    rst = 1'b1; can_store = 1'b1; mem_ready = 1'b1;
    tile_C_addr = 32'h1000; tile_C_stride = 32'h40; msize = 5'd4; nsize = 5'd8;
    #3;
    total++;
    if (obs !== ZERO) $display("FAIL reset_async: got %h expected %h", obs, ZERO);
    else passed++;
    @(negedge clk);
    total++;
    if (obs !== ZERO) $display("FAIL reset_held: got %h expected %h", obs, ZERO);
    else passed++;
    #1 rst = 1'b0; can_store = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== ZERO) $display("FAIL reset_idle: got %h expected %h", obs, ZERO);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    step_t s[6];
    tile_C_addr = 32'h1000; tile_C_stride = 32'h40; msize = 5'd4; nsize = 5'd8;
    s = '{
      '{1'b1, 1'b1, o(1'b1, 32'h1000, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0)},
      '{1'b1, 1'b1, o(1'b1, 32'h1040, 1'b1, 5'd8, 1'b1, 5'd1, 1'b0, 1'b1)},
      '{1'b1, 1'b1, o(1'b1, 32'h1080, 1'b1, 5'd8, 1'b1, 5'd2, 1'b0, 1'b1)},
      '{1'b1, 1'b1, o(1'b1, 32'h10C0, 1'b1, 5'd8, 1'b1, 5'd3, 1'b0, 1'b1)},
      '{1'b1, 1'b1, o(1'b0, 32'h0,    1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 1'b1)},
      '{1'b0, 1'b1, ZERO}
    };
    for (int i = 0; i < 6; i++) begin
      can_store = s[i].cs; mem_ready = s[i].mr;
      @(negedge clk);
      total++;
      if (obs !== s[i].exp) $display("FAIL basic step %0d: got %h expected %h", i, obs, s[i].exp);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    step_t s[8];
    tile_C_addr = 32'h1000; tile_C_stride = 32'h40; msize = 5'd4; nsize = 5'd8;
    s = '{
      '{1'b1, 1'b1, o(1'b1, 32'h1000, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0)},
      '{1'b1, 1'b1, o(1'b1, 32'h1040, 1'b1, 5'd8, 1'b1, 5'd1, 1'b0, 1'b1)},
      '{1'b1, 1'b1, o(1'b1, 32'h1080, 1'b1, 5'd8, 1'b1, 5'd2, 1'b0, 1'b1)},
      '{1'b1, 1'b0, o(1'b0, 32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1)},
      '{1'b1, 1'b0, o(1'b0, 32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1)},
      '{1'b1, 1'b1, o(1'b1, 32'h10C0, 1'b1, 5'd8, 1'b1, 5'd3, 1'b0, 1'b1)},
      '{1'b1, 1'b1, o(1'b0, 32'h0,    1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 1'b1)},
      '{1'b0, 1'b1, ZERO}
    };
    for (int i = 0; i < 8; i++) begin
      can_store = s[i].cs; mem_ready = s[i].mr;
      // Parameters change mid-store; the latched copies must be used.
      if (i == 1) begin
        tile_C_addr = 32'h9000; tile_C_stride = 32'h100; msize = 5'd2; nsize = 5'd3;
      end
      @(negedge clk);
      total++;
      if (obs !== s[i].exp) $display("FAIL stall step %0d: got %h expected %h", i, obs, s[i].exp);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    step_t s[5];
    tile_C_addr = 32'h3000; tile_C_stride = 32'h10; msize = 5'd1; nsize = 5'd4;
    s = '{
      '{1'b1, 1'b1, o(1'b1, 32'h3000, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0)},
      '{1'b1, 1'b1, o(1'b0, 32'h0,    1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 1'b1)},
      '{1'b1, 1'b1, o(1'b1, 32'h5000, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0)},
      '{1'b1, 1'b1, o(1'b0, 32'h0,    1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 1'b1)},
      '{1'b0, 1'b1, ZERO}
    };
    for (int i = 0; i < 5; i++) begin
      can_store = s[i].cs; mem_ready = s[i].mr;
      if (i == 1) tile_C_addr = 32'h5000;
      @(negedge clk);
      total++;
      if (obs !== s[i].exp) $display("FAIL single_b2b step %0d: got %h expected %h", i, obs, s[i].exp);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_empty();
    step_t s[2];
    tile_C_addr = 32'h7000; tile_C_stride = 32'h40; msize = 5'd0; nsize = 5'd8;
    s = '{
      '{1'b1, 1'b1, o(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0)},
      '{1'b0, 1'b1, ZERO}
    };
    for (int i = 0; i < 2; i++) begin
      can_store = s[i].cs; mem_ready = s[i].mr;
      @(negedge clk);
      total++;
      if (obs !== s[i].exp) $display("FAIL empty step %0d: got %h expected %h", i, obs, s[i].exp);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap();
    step_t s[4];
    tile_C_addr = 32'hFFFF_FFC0; tile_C_stride = 32'h40; msize = 5'd2; nsize = 5'd3;
    s = '{
      '{1'b1, 1'b1, o(1'b1, 32'hFFFF_FFC0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0)},
      '{1'b1, 1'b1, o(1'b1, 32'h0000_0000, 1'b1, 5'd3, 1'b1, 5'd1, 1'b0, 1'b1)},
      '{1'b1, 1'b1, o(1'b0, 32'h0,         1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 1'b1)},
      '{1'b0, 1'b1, ZERO}
    };
    for (int i = 0; i < 4; i++) begin
      can_store = s[i].cs; mem_ready = s[i].mr;
      @(negedge clk);
      total++;
      if (obs !== s[i].exp) $display("FAIL wrap step %0d: got %h expected %h", i, obs, s[i].exp);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset_abort();
    step_t s[3];
    step_t r[4];
    tile_C_addr = 32'h1000; tile_C_stride = 32'h40; msize = 5'd4; nsize = 5'd8;
    s = '{
      '{1'b1, 1'b1, o(1'b1, 32'h1000, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0)},
      '{1'b1, 1'b1, o(1'b1, 32'h1040, 1'b1, 5'd8, 1'b1, 5'd1, 1'b0, 1'b1)},
      '{1'b1, 1'b1, o(1'b1, 32'h1080, 1'b1, 5'd8, 1'b1, 5'd2, 1'b0, 1'b1)}
    };
    for (int i = 0; i < 3; i++) begin
      can_store = s[i].cs; mem_ready = s[i].mr;
      @(negedge clk);
      total++;
      if (obs !== s[i].exp) $display("FAIL rst_pre step %0d: got %h expected %h", i, obs, s[i].exp);
      else passed++;
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
    // Mid-cycle during row 1: outputs must drop without waiting for an edge.
    #2 rst = 1'b1;
    #1;
    total++;
    if (obs !== ZERO) $display("FAIL rst_mid_immediate: got %h expected %h", obs, ZERO);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (obs !== ZERO) $display("FAIL rst_mid_held: got %h expected %h", obs, ZERO);
    else passed++;
    @(negedge clk); #1;
    can_store = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    // Restart from row 0, then abort by dropping can_store mid-store.
    r = '{
      '{1'b1, 1'b1, o(1'b1, 32'h1000, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0)},
      '{1'b1, 1'b1, o(1'b1, 32'h1040, 1'b1, 5'd8, 1'b1, 5'd1, 1'b0, 1'b1)},
      '{1'b0, 1'b1, o(1'b0, 32'h0,    1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1)},
      '{1'b0, 1'b1, ZERO}
    };
    for (int i = 0; i < 4; i++) begin
      can_store = r[i].cs; mem_ready = r[i].mr;
      @(negedge clk);
      total++;
      if (obs !== r[i].exp) $display("FAIL restart_abort step %0d: got %h expected %h", i, obs, r[i].exp);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_empty();
    test_wrap();
    test_async_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_gemm_store_controller
